// File: rtl/lvds_frame_deser.sv
// Multi-lane serial-to-parallel framer: realigns on each frame edge, qualifies lock, flags framing errors.
// Build macro LVDS_FRAME_DESER_STATS_EN adds a saturating frame-error counter output (err_count).
module lvds_frame_deser #(
   parameter int WORD_BITS   = 12,
   parameter int NUM_LANES   = 1,
   parameter int LOCK_FRAMES = 4,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           frame_in,
   input  logic [NUM_LANES-1:0]           data_in,
   output logic [NUM_LANES*WORD_BITS-1:0] data_out,
   output logic                           word_valid,
   output logic                           locked,
   output logic                           frame_err
`ifdef LVDS_FRAME_DESER_STATS_EN
   ,
   output logic [15:0]                    err_count
`endif
);
   localparam int            CW     = $clog2(WORD_BITS + 2);
   localparam int            PW     = WORD_BITS - 1;
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_FULL = CW'(WORD_BITS);
   localparam logic [CW-1:0] C_LAST = CW'(WORD_BITS - 1);
   localparam logic [CW-1:0] C_SAT  = CW'(WORD_BITS + 1);
   localparam logic [7:0]    C_LOCK = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} state_t;

   state_t                         r_state, w_state_next;
   logic                           r_frame_q;
   logic [CW-1:0]                  r_bit_cnt, w_bit_cnt_next;
   logic [7:0]                     r_good_cnt, w_good_cnt_next;
   logic [NUM_LANES*PW-1:0]        r_part, w_part_next;
   logic [NUM_LANES*WORD_BITS-1:0] w_word;
   logic [NUM_LANES*WORD_BITS-1:0] r_data_out;
   logic                           r_word_valid, r_locked, r_frame_err;
   logic                           w_edge, w_emit, w_err;

   assign w_edge = frame_in & ~r_frame_q;

   // Only the earlier WORD_BITS-1 bits are stored; the current bit completes the word combinationally.
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      if (MSB_FIRST) begin : g_msb
         assign w_word[gi*WORD_BITS +: WORD_BITS] = {r_part[gi*PW +: PW], data_in[gi]};
         assign w_part_next[gi*PW +: PW]          = w_word[gi*WORD_BITS +: PW];
      end else begin : g_lsb
         assign w_word[gi*WORD_BITS +: WORD_BITS] = {data_in[gi], r_part[gi*PW +: PW]};
         assign w_part_next[gi*PW +: PW]          = w_word[gi*WORD_BITS+1 +: PW];
      end
   end

   assign w_bit_cnt_next = w_edge ? C_ONE :
                           (r_bit_cnt == C_SAT) ? C_SAT : r_bit_cnt + C_ONE;

   always_comb begin
      w_state_next    = r_state;
      w_good_cnt_next = r_good_cnt;
      w_emit          = 1'b0;
      w_err           = 1'b0;
      case (r_state)
         SEEK: begin
            if (w_edge) begin
               w_state_next    = ACQUIRE;
               w_good_cnt_next = '0;
            end
         end
         ACQUIRE, LOCKED: begin
            if (w_edge) begin
               if (r_bit_cnt == C_FULL) begin
                  if (r_state == ACQUIRE) begin
                     w_good_cnt_next = r_good_cnt + 8'd1;
                     if (w_good_cnt_next >= C_LOCK) begin
                        w_state_next = LOCKED;
                     end
                  end
               end else begin
                  // Early edge: keep it as the new alignment but restart qualification.
                  w_err           = 1'b1;
                  w_state_next    = ACQUIRE;
                  w_good_cnt_next = '0;
               end
            end else if (r_bit_cnt == C_FULL) begin
               w_err           = 1'b1;
               w_state_next    = SEEK;
               w_good_cnt_next = '0;
            end else if ((r_state == LOCKED) && (r_bit_cnt == C_LAST)) begin
               w_emit = 1'b1;
            end
         end
         default: w_state_next = SEEK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= SEEK;
         r_frame_q    <= 1'b0;
         r_bit_cnt    <= '0;
         r_good_cnt   <= '0;
         r_part       <= '0;
         r_data_out   <= '0;
         r_word_valid <= 1'b0;
         r_locked     <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_frame_q    <= frame_in;
         r_bit_cnt    <= w_bit_cnt_next;
         r_good_cnt   <= w_good_cnt_next;
         r_part       <= w_part_next;
         r_word_valid <= w_emit;
         r_locked     <= (w_state_next == LOCKED);
         r_frame_err  <= w_err;
         if (w_emit) begin
            r_data_out <= w_word;
         end
      end
   end

   assign data_out   = r_data_out;
   assign word_valid = r_word_valid;
   assign locked     = r_locked;
   assign frame_err  = r_frame_err;

`ifdef LVDS_FRAME_DESER_STATS_EN
   logic [15:0] r_err_count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_err_count <= '0;
      end else if (w_err && (r_err_count != 16'hFFFF)) begin
         r_err_count <= r_err_count + 16'd1;
      end
   end

   assign err_count = r_err_count;
`endif
endmodule
